// File: rtl/cdb_pkg.sv
// Shared common-data-bus types and defaults used by the arbiter, RS and ROB.
package cdb_pkg;

    localparam int unsigned CDB_NUM_BUSES = 1;
    localparam int unsigned CDB_TAG_W     = 5;
    localparam int unsigned CDB_XLEN      = 32;

    typedef struct packed {
        logic                 valid;
        logic [CDB_TAG_W-1:0] tag;
        logic [CDB_XLEN-1:0]  value;
    } cdb_packet_t;

    // Increment an index and wrap it back to zero at modulus n (any n, not only powers of 2).
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side handshake and broadcast-side bus signals of the CDB arbiter.
interface cdb_arbiter_if #(
    parameter int unsigned NUM_FU  = 5,
    parameter int unsigned NUM_CDB = cdb_pkg::CDB_NUM_BUSES,
    parameter int unsigned TAG_W   = cdb_pkg::CDB_TAG_W,
    parameter int unsigned XLEN    = cdb_pkg::CDB_XLEN
);
    localparam int unsigned SRC_W = $clog2(NUM_FU);

    logic [NUM_FU-1:0]             fu_valid;
    logic [NUM_FU-1:0][TAG_W-1:0]  fu_tag;
    logic [NUM_FU-1:0][XLEN-1:0]   fu_value;
    logic [NUM_FU-1:0]             fu_ready;
    logic [NUM_CDB-1:0]            cdb_valid;
    logic [NUM_CDB-1:0][TAG_W-1:0] cdb_tag;
    logic [NUM_CDB-1:0][XLEN-1:0]  cdb_value;
    logic [NUM_CDB-1:0][SRC_W-1:0] cdb_src;

    modport master (
        output fu_valid, fu_tag, fu_value,
        input  fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_src
    );

    modport slave (
        input  fu_valid, fu_tag, fu_value,
        output fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_src
    );

endinterface

// File: rtl/cdb_fu_queue.sv
// Per-FU result FIFO: holds completed results until they win a CDB slot.
module cdb_fu_queue
    import cdb_pkg::*;
#(
    parameter int unsigned TAG_W = CDB_TAG_W,
    parameter int unsigned XLEN  = CDB_XLEN,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             squash,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic [XLEN-1:0]  push_value,
    input  logic             pop,
    output logic [TAG_W-1:0] head_tag,
    output logic [XLEN-1:0]  head_value,
    output logic             empty,
    output logic             full
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0] tag_mem   [DEPTH];
    logic [XLEN-1:0]  value_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full && !squash;
    assign do_pop   = pop && !empty;
    assign head_tag   = tag_mem[rd_ptr];
    assign head_value = value_mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset and squash both empty the queue.
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= PTR_W'(wrap_inc(32'(wr_ptr), DEPTH));
            end
            if (do_pop) begin
                rd_ptr <= PTR_W'(wrap_inc(32'(rd_ptr), DEPTH));
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Payload storage; needs no reset because occupancy is tracked by count.
    always_ff @(posedge clock) begin
        if (do_push) begin
            tag_mem[wr_ptr]   <= push_tag;
            value_mem[wr_ptr] <= push_value;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Buffered multi-bus CDB arbiter: queues FU results and broadcasts up to NUM_CDB per cycle.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned NUM_FU    = 5,
    parameter int unsigned NUM_CDB   = CDB_NUM_BUSES,
    parameter int unsigned TAG_W     = CDB_TAG_W,
    parameter int unsigned XLEN      = CDB_XLEN,
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned RR_MODE   = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          squash,
    cdb_arbiter_if.slave  bus
);
    localparam int unsigned SRC_W = $clog2(NUM_FU);

    logic [NUM_FU-1:0]            empty;
    logic [NUM_FU-1:0]            full;
    logic [NUM_FU-1:0]            grant;
    logic [NUM_FU-1:0][TAG_W-1:0] head_tag;
    logic [NUM_FU-1:0][XLEN-1:0]  head_value;
    logic [SRC_W-1:0]             rr_ptr;
    logic [SRC_W-1:0]             last_idx;
    logic                         any_grant;
    int unsigned                  won;
    int unsigned                  idx;

    // One output queue per producing functional unit.
    for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
        cdb_fu_queue #(
            .TAG_W (TAG_W),
            .XLEN  (XLEN),
            .DEPTH (BUF_DEPTH)
        ) u_queue (
            .clock      (clock),
            .reset      (reset),
            .squash     (squash),
            .push       (bus.fu_valid[g]),
            .push_tag   (bus.fu_tag[g]),
            .push_value (bus.fu_value[g]),
            .pop        (grant[g]),
            .head_tag   (head_tag[g]),
            .head_value (head_value[g]),
            .empty      (empty[g]),
            .full       (full[g])
        );
    end

    assign bus.fu_ready = ~full;

    // Walk FUs in search order; the k-th non-empty FU found drives bus k.
    always_comb begin
        grant         = '0;
        any_grant     = 1'b0;
        last_idx      = '0;
        won           = 0;
        idx           = 0;
        bus.cdb_valid = '0;
        bus.cdb_tag   = '0;
        bus.cdb_value = '0;
        bus.cdb_src   = '0;
        for (int unsigned j = 0; j < NUM_FU; j++) begin
            idx = (RR_MODE != 0) ? ((32'(rr_ptr) + j) % NUM_FU) : j;
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (i == idx && !empty[i] && !squash && won < NUM_CDB) begin
                    grant[i]  = 1'b1;
                    any_grant = 1'b1;
                    last_idx  = SRC_W'(i);
                    for (int unsigned k = 0; k < NUM_CDB; k++) begin
                        if (k == won) begin
                            bus.cdb_valid[k] = 1'b1;
                            bus.cdb_tag[k]   = head_tag[i];
                            bus.cdb_value[k] = head_value[i];
                            bus.cdb_src[k]   = SRC_W'(i);
                        end
                    end
                    won = won + 1;
                end
            end
        end
    end

    // Round-robin pointer moves just past the last FU granted this cycle.
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            rr_ptr <= '0;
        end else if (any_grant) begin
            rr_ptr <= SRC_W'(wrap_inc(32'(last_idx), NUM_FU));
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for cdb_arbiter in three configurations.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    typedef struct packed {
        cdb_packet_t pkt;
        logic [2:0]  src;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    logic sq_a;
    logic sq_b;
    logic sq_c;
    int   checks   = 0;
    int   failures = 0;

    // Expected broadcasts per bus: 0 = a bus0, 1 = b bus0, 2 = c bus0, 3 = c bus1.
    exp_t sb [4][$];

    always #5 clock = ~clock;

    cdb_arbiter_if #(.NUM_FU(5), .NUM_CDB(1), .TAG_W(5), .XLEN(32)) if_a ();
    cdb_arbiter_if #(.NUM_FU(5), .NUM_CDB(1), .TAG_W(5), .XLEN(32)) if_b ();
    cdb_arbiter_if #(.NUM_FU(5), .NUM_CDB(2), .TAG_W(5), .XLEN(32)) if_c ();

    cdb_arbiter #(.NUM_FU(5), .NUM_CDB(1), .TAG_W(5), .XLEN(32), .BUF_DEPTH(2), .RR_MODE(1)) dut_a (
        .clock(clock), .reset(reset), .squash(sq_a), .bus(if_a.slave));
    cdb_arbiter #(.NUM_FU(5), .NUM_CDB(1), .TAG_W(5), .XLEN(32), .BUF_DEPTH(2), .RR_MODE(0)) dut_b (
        .clock(clock), .reset(reset), .squash(sq_b), .bus(if_b.slave));
    cdb_arbiter #(.NUM_FU(5), .NUM_CDB(2), .TAG_W(5), .XLEN(32), .BUF_DEPTH(2), .RR_MODE(1)) dut_c (
        .clock(clock), .reset(reset), .squash(sq_c), .bus(if_c.slave));

    function automatic logic [31:0] val_of(input logic [4:0] t);
        return 32'hA500_0000 + 32'(t);
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic push_exp(input int q, input logic [4:0] t, input logic [31:0] v, input logic [2:0] s);
        exp_t e;
        e.pkt.valid = 1'b1;
        e.pkt.tag   = t;
        e.pkt.value = v;
        e.src       = s;
        sb[q].push_back(e);
    endtask

    task automatic mon_bus(input int q, input string name, input logic v, input logic [4:0] t,
                           input logic [31:0] val, input logic [2:0] s);
        exp_t e;
        if (v === 1'b1) begin
            checks++;
            assert (sb[q].size() != 0) else begin
                failures++;
                $error("FAIL %s_unexpected observed=tag %0h src %0d expected=no broadcast", name, t, s);
            end
            if (sb[q].size() != 0) begin
                e = sb[q].pop_front();
                chk({name, "_tag"}, 64'(t), 64'(e.pkt.tag));
                chk({name, "_value"}, 64'(val), 64'(e.pkt.value));
                chk({name, "_src"}, 64'(s), 64'(e.src));
            end
        end
    endtask

    // Scoreboard monitor: every broadcast must match the next expected result in order.
    always @(negedge clock) begin
        if (!reset) begin
            mon_bus(0, "a_bus0", if_a.cdb_valid[0], if_a.cdb_tag[0], if_a.cdb_value[0], if_a.cdb_src[0]);
            mon_bus(1, "b_bus0", if_b.cdb_valid[0], if_b.cdb_tag[0], if_b.cdb_value[0], if_b.cdb_src[0]);
            mon_bus(2, "c_bus0", if_c.cdb_valid[0], if_c.cdb_tag[0], if_c.cdb_value[0], if_c.cdb_src[0]);
            mon_bus(3, "c_bus1", if_c.cdb_valid[1], if_c.cdb_tag[1], if_c.cdb_value[1], if_c.cdb_src[1]);
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all();
        if_a.fu_valid = '0; if_a.fu_tag = '0; if_a.fu_value = '0;
        if_b.fu_valid = '0; if_b.fu_tag = '0; if_b.fu_value = '0;
        if_c.fu_valid = '0; if_c.fu_tag = '0; if_c.fu_value = '0;
    endtask

    initial begin
        reset = 1'b1;
        sq_a  = 1'b0;
        sq_b  = 1'b0;
        sq_c  = 1'b0;
        idle_all();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_ready_a", 64'(if_a.fu_ready), 64'h1f);
        chk("rst_ready_c", 64'(if_c.fu_ready), 64'h1f);
        chk("rst_valid_a", 64'(if_a.cdb_valid), 64'h0);
        chk("rst_tag_a", 64'(if_a.cdb_tag), 64'h0);
        chk("rst_value_a", 64'(if_a.cdb_value), 64'h0);
        chk("rst_src_a", 64'(if_a.cdb_src), 64'h0);
        chk("rst_valid_c", 64'(if_c.cdb_valid), 64'h0);

        // Single push from FU2: visible exactly one cycle later.
        next_cycle();
        if_a.fu_valid = 5'b00100; if_a.fu_tag[2] = 5'd5; if_a.fu_value[2] = 32'hA;
        push_exp(0, 5'd5, 32'hA, 3'd2);
        @(negedge clock);
        chk("t1_same_cycle_valid", 64'(if_a.cdb_valid), 64'h0);
        next_cycle();
        if_a.fu_valid = '0;
        @(negedge clock);
        chk("t1_valid", 64'(if_a.cdb_valid), 64'h1);
        chk("t1_tag", 64'(if_a.cdb_tag[0]), 64'd5);
        chk("t1_value", 64'(if_a.cdb_value[0]), 64'hA);
        chk("t1_src", 64'(if_a.cdb_src[0]), 64'd2);
        next_cycle();
        @(negedge clock);
        chk("t1_after_valid", 64'(if_a.cdb_valid), 64'h0);

        // Reset with results queued discards them.
        next_cycle();
        if_a.fu_valid = 5'b01100;
        if_a.fu_tag[2] = 5'd6; if_a.fu_value[2] = val_of(5'd6);
        if_a.fu_tag[3] = 5'd7; if_a.fu_value[3] = val_of(5'd7);
        next_cycle();
        if_a.fu_valid = '0;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        chk("rstmid_valid", 64'(if_a.cdb_valid), 64'h0);
        chk("rstmid_ready", 64'(if_a.fu_ready), 64'h1f);

        // Round robin with FUs 0, 1, 3 pushing together.
        next_cycle();
        if_a.fu_valid = 5'b01011;
        if_a.fu_tag[0] = 5'd1; if_a.fu_value[0] = val_of(5'd1);
        if_a.fu_tag[1] = 5'd2; if_a.fu_value[1] = val_of(5'd2);
        if_a.fu_tag[3] = 5'd3; if_a.fu_value[3] = val_of(5'd3);
        push_exp(0, 5'd1, val_of(5'd1), 3'd0);
        push_exp(0, 5'd2, val_of(5'd2), 3'd1);
        push_exp(0, 5'd3, val_of(5'd3), 3'd3);
        next_cycle();
        if_a.fu_valid = '0;
        @(negedge clock);
        chk("t2_c1_src", 64'(if_a.cdb_src[0]), 64'd0);
        next_cycle();
        @(negedge clock);
        chk("t2_c2_src", 64'(if_a.cdb_src[0]), 64'd1);
        next_cycle();
        @(negedge clock);
        chk("t2_c3_src", 64'(if_a.cdb_src[0]), 64'd3);
        // Pointer now at 4: FU4 must beat FU0.
        next_cycle();
        if_a.fu_valid = 5'b10001;
        if_a.fu_tag[0] = 5'd9;  if_a.fu_value[0] = val_of(5'd9);
        if_a.fu_tag[4] = 5'd10; if_a.fu_value[4] = val_of(5'd10);
        push_exp(0, 5'd10, val_of(5'd10), 3'd4);
        push_exp(0, 5'd9, val_of(5'd9), 3'd0);
        next_cycle();
        if_a.fu_valid = '0;
        @(negedge clock);
        chk("ptr4_first_src", 64'(if_a.cdb_src[0]), 64'd4);
        next_cycle();
        @(negedge clock);
        chk("ptr4_second_src", 64'(if_a.cdb_src[0]), 64'd0);

        // FU0 full and popped with a new push: push rejected, order kept.
        next_cycle();
        if_a.fu_valid = 5'b00011;
        if_a.fu_tag[0] = 5'd12; if_a.fu_value[0] = val_of(5'd12);
        if_a.fu_tag[1] = 5'd13; if_a.fu_value[1] = val_of(5'd13);
        push_exp(0, 5'd13, val_of(5'd13), 3'd1);
        push_exp(0, 5'd12, val_of(5'd12), 3'd0);
        push_exp(0, 5'd14, val_of(5'd14), 3'd0);
        next_cycle();
        if_a.fu_valid = 5'b00001;
        if_a.fu_tag[0] = 5'd14; if_a.fu_value[0] = val_of(5'd14);
        @(negedge clock);
        chk("full_c1_src", 64'(if_a.cdb_src[0]), 64'd1);
        chk("full_c1_ready0", 64'(if_a.fu_ready[0]), 64'd1);
        next_cycle();
        if_a.fu_tag[0] = 5'd15; if_a.fu_value[0] = val_of(5'd15);
        @(negedge clock);
        chk("full_c2_ready0", 64'(if_a.fu_ready[0]), 64'd0);
        chk("full_c2_tag", 64'(if_a.cdb_tag[0]), 64'd12);
        next_cycle();
        if_a.fu_valid = '0;
        @(negedge clock);
        chk("full_c3_ready0", 64'(if_a.fu_ready[0]), 64'd1);
        chk("full_c3_tag", 64'(if_a.cdb_tag[0]), 64'd14);
        next_cycle();
        @(negedge clock);
        chk("full_c4_valid", 64'(if_a.cdb_valid), 64'h0);

        // Fixed priority: FU0 streams, FU4 waits and fills.
        next_cycle();
        if_b.fu_valid = 5'b10001;
        if_b.fu_tag[0] = 5'd16; if_b.fu_value[0] = val_of(5'd16);
        if_b.fu_tag[4] = 5'd28; if_b.fu_value[4] = val_of(5'd28);
        push_exp(1, 5'd16, val_of(5'd16), 3'd0);
        next_cycle();
        if_b.fu_tag[0] = 5'd17; if_b.fu_value[0] = val_of(5'd17);
        if_b.fu_tag[4] = 5'd29; if_b.fu_value[4] = val_of(5'd29);
        push_exp(1, 5'd17, val_of(5'd17), 3'd0);
        @(negedge clock);
        chk("fp_c1_src", 64'(if_b.cdb_src[0]), 64'd0);
        chk("fp_c1_ready4", 64'(if_b.fu_ready[4]), 64'd1);
        for (int n = 2; n <= 5; n++) begin
            next_cycle();
            if_b.fu_tag[0] = 5'(16 + n); if_b.fu_value[0] = val_of(5'(16 + n));
            if_b.fu_tag[4] = 5'd30; if_b.fu_value[4] = val_of(5'd30);
            push_exp(1, 5'(16 + n), val_of(5'(16 + n)), 3'd0);
            @(negedge clock);
            chk("fp_loop_ready4", 64'(if_b.fu_ready[4]), 64'd0);
            chk("fp_loop_src", 64'(if_b.cdb_src[0]), 64'd0);
            chk("fp_loop_tag", 64'(if_b.cdb_tag[0]), 64'(16 + n - 1));
        end
        next_cycle();
        if_b.fu_valid = '0;
        push_exp(1, 5'd28, val_of(5'd28), 3'd4);
        push_exp(1, 5'd29, val_of(5'd29), 3'd4);
        @(negedge clock);
        chk("fp_last_fu0_tag", 64'(if_b.cdb_tag[0]), 64'd21);
        next_cycle();
        @(negedge clock);
        chk("fp_fu4_first_src", 64'(if_b.cdb_src[0]), 64'd4);
        chk("fp_fu4_first_ready", 64'(if_b.fu_ready[4]), 64'd0);
        next_cycle();
        @(negedge clock);
        chk("fp_fu4_second_tag", 64'(if_b.cdb_tag[0]), 64'd29);
        chk("fp_fu4_second_ready", 64'(if_b.fu_ready[4]), 64'd1);
        next_cycle();
        @(negedge clock);
        chk("fp_drained_valid", 64'(if_b.cdb_valid), 64'h0);

        // Squash with FU3 full behind FU0; a push in the squash cycle is dropped.
        next_cycle();
        if_b.fu_valid = 5'b01001;
        if_b.fu_tag[0] = 5'd1; if_b.fu_value[0] = val_of(5'd1);
        if_b.fu_tag[3] = 5'd7; if_b.fu_value[3] = val_of(5'd7);
        push_exp(1, 5'd1, val_of(5'd1), 3'd0);
        next_cycle();
        if_b.fu_tag[0] = 5'd2; if_b.fu_value[0] = val_of(5'd2);
        if_b.fu_tag[3] = 5'd8; if_b.fu_value[3] = val_of(5'd8);
        @(negedge clock);
        chk("sq_pre_tag", 64'(if_b.cdb_tag[0]), 64'd1);
        next_cycle();
        if_b.fu_valid = 5'b00010;
        if_b.fu_tag[1] = 5'd9; if_b.fu_value[1] = val_of(5'd9);
        sq_b = 1'b1;
        @(negedge clock);
        chk("sq_valid", 64'(if_b.cdb_valid), 64'h0);
        chk("sq_ready3_full", 64'(if_b.fu_ready[3]), 64'd0);
        next_cycle();
        sq_b = 1'b0;
        if_b.fu_valid = '0;
        @(negedge clock);
        chk("sq_after_valid", 64'(if_b.cdb_valid), 64'h0);
        chk("sq_after_ready", 64'(if_b.fu_ready), 64'h1f);
        next_cycle();
        @(negedge clock);
        chk("sq_after2_valid", 64'(if_b.cdb_valid), 64'h0);

        // Two buses: FU1 and FU4 share a cycle, then FU0/2/3 split over two cycles.
        next_cycle();
        if_c.fu_valid = 5'b10010;
        if_c.fu_tag[1] = 5'd1; if_c.fu_value[1] = val_of(5'd1);
        if_c.fu_tag[4] = 5'd4; if_c.fu_value[4] = val_of(5'd4);
        push_exp(2, 5'd1, val_of(5'd1), 3'd1);
        push_exp(3, 5'd4, val_of(5'd4), 3'd4);
        next_cycle();
        if_c.fu_tag[1] = 5'd11; if_c.fu_value[1] = val_of(5'd11);
        if_c.fu_tag[4] = 5'd14; if_c.fu_value[4] = val_of(5'd14);
        push_exp(2, 5'd11, val_of(5'd11), 3'd1);
        push_exp(3, 5'd14, val_of(5'd14), 3'd4);
        @(negedge clock);
        chk("dual_c1_valid", 64'(if_c.cdb_valid), 64'h3);
        chk("dual_c1_src0", 64'(if_c.cdb_src[0]), 64'd1);
        chk("dual_c1_src1", 64'(if_c.cdb_src[1]), 64'd4);
        next_cycle();
        if_c.fu_valid = 5'b01101;
        if_c.fu_tag[0] = 5'd16; if_c.fu_value[0] = val_of(5'd16);
        if_c.fu_tag[2] = 5'd18; if_c.fu_value[2] = val_of(5'd18);
        if_c.fu_tag[3] = 5'd19; if_c.fu_value[3] = val_of(5'd19);
        push_exp(2, 5'd16, val_of(5'd16), 3'd0);
        push_exp(3, 5'd18, val_of(5'd18), 3'd2);
        push_exp(2, 5'd19, val_of(5'd19), 3'd3);
        @(negedge clock);
        chk("dual_c2_valid", 64'(if_c.cdb_valid), 64'h3);
        chk("dual_c2_tag0", 64'(if_c.cdb_tag[0]), 64'd11);
        chk("dual_c2_tag1", 64'(if_c.cdb_tag[1]), 64'd14);
        next_cycle();
        if_c.fu_valid = '0;
        @(negedge clock);
        chk("dual_c3_src0", 64'(if_c.cdb_src[0]), 64'd0);
        chk("dual_c3_src1", 64'(if_c.cdb_src[1]), 64'd2);
        next_cycle();
        @(negedge clock);
        chk("dual_c4_valid", 64'(if_c.cdb_valid), 64'h1);
        chk("dual_c4_src0", 64'(if_c.cdb_src[0]), 64'd3);
        chk("dual_c4_bus1_tag", 64'(if_c.cdb_tag[1]), 64'h0);
        chk("dual_c4_bus1_value", 64'(if_c.cdb_value[1]), 64'h0);
        chk("dual_c4_bus1_src", 64'(if_c.cdb_src[1]), 64'h0);
        next_cycle();
        @(negedge clock);
        chk("dual_c5_valid", 64'(if_c.cdb_valid), 64'h0);

        next_cycle();
        @(negedge clock);
        chk("sb_a_empty", 64'(sb[0].size()), 64'd0);
        chk("sb_b_empty", 64'(sb[1].size()), 64'd0);
        chk("sb_c0_empty", 64'(sb[2].size()), 64'd0);
        chk("sb_c1_empty", 64'(sb[3].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Parametrised common-data-bus arbiter for the out-of-order core. It collects completed results from NUM_FU functional units, holds each in a small per-FU output queue, and broadcasts up to NUM_CDB results per cycle to the RS/ROB/map table. Arbitration is fixed-priority or round-robin, and the unit squashes on branch mispredict. It replaces the single-bus, unbuffered, fixed-priority CDB mux.

Parameters:
NUM_FU, 5, number of producing functional-unit channels (>=2)
NUM_CDB, 1, number of broadcast buses per cycle (1..NUM_FU)
TAG_W, 5, ROB/physical tag width
XLEN, 32, result value width
BUF_DEPTH, 2, entries per FU output queue (>=1)
RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
squash  in  1  mispredict flush
fu_valid  in  [NUM_FU]  FU presents a result
fu_tag  in  [NUM_FU][TAG_W]  result tag
fu_value  in  [NUM_FU][XLEN]  result value
fu_ready  out  [NUM_FU]  queue can accept this cycle
cdb_valid  out  [NUM_CDB]  bus k carries a result
cdb_tag  out  [NUM_CDB][TAG_W]  broadcast tag
cdb_value  out  [NUM_CDB][XLEN]  broadcast value
cdb_src  out  [NUM_CDB][$clog2(NUM_FU)]  granted FU index, debug

Behaviour:
- Interface: one clock `clock`. `reset` is synchronous and active-high. All state updates on posedge clock.
- Reset: all queues empty, count=0, rr_ptr=0. cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0. fu_ready=1 in the cycle after reset deasserts.
- Push: the entry is accepted when fu_valid[i] && fu_ready[i]. fu_ready[i] = (count_i < BUF_DEPTH) and depends on registered count only; no same-cycle pop bypass, so there is no comb path from grant to ready.
- A push accepted at edge t is eligible for broadcast in cycle t+1. Minimum FU-to-CDB latency is 1 cycle.
- Broadcast outputs are driven combinationally from the registered queue heads. Each queue's head is popped at the edge ending the cycle in which it is granted.
- Grant: at most one entry per FU per cycle. Up to NUM_CDB distinct non-empty FUs are granted. The k-th winner in search order drives bus k. Unused buses have valid=0 and zero tag/value/src.
- Fixed mode search order: index 0..NUM_FU-1.
- RR mode search order: rr_ptr, rr_ptr+1, ... mod NUM_FU. If any grant occurs, rr_ptr <= (last granted index + 1) mod NUM_FU. Otherwise rr_ptr holds.
- Simultaneous push and pop on a non-full queue: count unchanged and FIFO order preserved. A full queue rejects the push even if it is popped that cycle.
- Queue pointers wrap modulo BUF_DEPTH, including non-power-of-2 depths.
- Squash: cdb_valid forced 0 in the squash cycle. All queues are cleared at that edge. Pushes in the squash cycle are dropped. rr_ptr resets to 0.
- Reset has priority over squash. Reset mid-operation discards all queued results.
- When all buses are busy, remaining FUs wait in their queues. Starvation-free in RR mode only.

Decomposition:
- Shared package cdb_pkg: typedef CDB_PACKET {logic valid; logic [TAG_W-1:0] tag; logic [XLEN-1:0] value;}, plus a default NUM_CDB constant used by the RS and ROB.
- Sub-module cdb_fu_queue: a per-FU BUF_DEPTH FIFO with push/pop/squash, head output and full flag. It is instantiated NUM_FU times in a generate loop.
- Arbitration is a function or always_comb block inside cdb_arbiter.

Test Plan:
- Reset, then push FU2 tag=5 val=0xA -> next cycle cdb_valid[0]=1, tag=5, value=0xA, src=2; following cycle valid=0.
- NUM_CDB=1, RR_MODE=1: FUs 0, 1 and 3 push in the same cycle -> broadcasts over 3 cycles in order src 0, 1, 3; rr_ptr ends at 4.
- RR_MODE=0: FU0 pushes every cycle, FU4 pushes once -> FU0 always wins; FU4 waits and fu_ready[4]=0 once its queue is full (BUF_DEPTH=2).
- NUM_CDB=2: FUs 1 and 4 both valid -> bus0=src1 and bus1=src4 in the same cycle; queues drain.
- Fill FU3 queue (tags 7, 8) with the bus blocked, then assert squash -> cdb_valid=0 that cycle, no broadcast afterwards, fu_ready[3]=1 next cycle.
- FU0 queue full and popped, with a simultaneous fu_valid -> push rejected; count decrements to 1; the order of remaining tags is preserved.
